// File: rtl/uart_tx_if.sv
// UART transmitter byte-side interface.
// Master offers bytes; slave reports line and FIFO state.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic [2:0] fifo_count;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx, tx_busy, fifo_count
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx, tx_busy, fifo_count
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with a 4-entry input FIFO.
// Start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic     clk,
   input  logic     reset,
   uart_tx_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [15:0] LP_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic        LP_STOP2 = (STOP_BITS == 2);
   localparam logic        LP_PEN   = (PARITY_EN != 0);
   localparam logic        LP_ODD   = (PARITY_ODD != 0);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_baud, w_baud_nxt;
   logic [2:0]  r_bit, w_bit_nxt;
   logic        r_stop, w_stop_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_tx, w_tx_nxt;
   logic        r_busy;
   logic [7:0]  r_mem [4];
   logic [1:0]  r_wptr, r_rptr;
   logic [2:0]  r_count;
   logic        w_push, w_pop, w_last;

   assign bus.tx_ready   = (r_count != 3'd4);
   assign bus.tx         = r_tx;
   assign bus.tx_busy    = r_busy;
   assign bus.fifo_count = r_count;

   assign w_push = bus.tx_valid && (r_count != 3'd4);
   assign w_pop  = (r_state == S_IDLE) && (r_count != 3'd0);
   assign w_last = (r_baud == LP_LAST);

   // FIFO storage; validity is tracked by r_count, so no reset needed
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= bus.tx_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 2'd1;
         if (w_pop)  r_rptr <= r_rptr + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM state, counters and registered line outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_stop  <= 1'b0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_stop  <= w_stop_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   // Next state; line level is derived from the next state so tx is aligned
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + 16'd1;
      w_bit_nxt   = r_bit;
      w_stop_nxt  = r_stop;
      w_shift_nxt = r_shift;
      w_tx_nxt    = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (w_pop) begin
               w_state_nxt = S_START;
               w_shift_nxt = r_mem[r_rptr];
               w_bit_nxt   = '0;
               w_stop_nxt  = 1'b0;
            end
         end
         S_START: begin
            if (w_last) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_last) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_state_nxt = LP_PEN ? S_PARITY : S_STOP;
                  w_stop_nxt  = 1'b0;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (w_last) begin
               w_state_nxt = S_STOP;
               w_baud_nxt  = '0;
               w_stop_nxt  = 1'b0;
            end
         end
         S_STOP: begin
            if (w_last) begin
               w_baud_nxt = '0;
               if (r_stop == LP_STOP2) w_state_nxt = S_IDLE;
               else                    w_stop_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_baud_nxt  = '0;
         end
      endcase
      unique case (w_state_nxt)
         S_IDLE:   w_tx_nxt = 1'b1;
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shift_nxt[w_bit_nxt];
         S_PARITY: w_tx_nxt = (^w_shift_nxt) ^ LP_ODD;
         S_STOP:   w_tx_nxt = 1'b1;
         default:  w_tx_nxt = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four parameter sets checked against a
// frame model built from the serial framing rules.
module tb_uart_tx;
   localparam int CPB = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_tx_if if0 ();
   uart_tx_if if1 ();
   uart_tx_if if2 ();
   uart_tx_if if3 ();

   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
      u0 (.clk(clk), .reset(reset), .bus(if0));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
      u1 (.clk(clk), .reset(reset), .bus(if1));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
      u2 (.clk(clk), .reset(reset), .bus(if2));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
      u3 (.clk(clk), .reset(reset), .bus(if3));

   int par_en  [4] = '{0, 1, 1, 0};
   int par_odd [4] = '{0, 0, 1, 0};
   int stops   [4] = '{1, 1, 1, 2};

   logic [7:0] dat [4];
   logic       val [4];
   logic [3:0] w_tx, w_busy, w_rdy;
   logic [2:0] w_cnt [4];

   assign if0.tx_data = dat[0];
   assign if1.tx_data = dat[1];
   assign if2.tx_data = dat[2];
   assign if3.tx_data = dat[3];
   assign if0.tx_valid = val[0];
   assign if1.tx_valid = val[1];
   assign if2.tx_valid = val[2];
   assign if3.tx_valid = val[3];
   assign w_tx   = {if3.tx, if2.tx, if1.tx, if0.tx};
   assign w_busy = {if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};
   assign w_rdy  = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};
   assign w_cnt[0] = if0.fifo_count;
   assign w_cnt[1] = if1.fifo_count;
   assign w_cnt[2] = if2.fifo_count;
   assign w_cnt[3] = if3.fifo_count;

   int ntests = 0;
   int nfail  = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      ntests++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected line level per clock for one frame, bit 0 = first start cycle
   function automatic void model(input int idx, input logic [7:0] b,
                                 output logic [63:0] v, output int len);
      logic q[$];
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
      if (par_en[idx] != 0) q.push_back((^b) ^ par_odd[idx][0]);
      for (int s = 0; s < stops[idx]; s++) q.push_back(1'b1);
      len = q.size() * CPB;
      v = '0;
      for (int k = 0; k < len; k++) v[k] = q[k / CPB];
   endfunction

   task automatic push(input int idx, input logic [7:0] b);
      val[idx] = 1'b1;
      dat[idx] = b;
      @(negedge clk);
      val[idx] = 1'b0;
   endtask

   task automatic wait_start(input int idx, output int waited);
      waited = 0;
      while (w_tx[idx] !== 1'b0 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 300) check("start_timeout", 64'(w_tx[idx]), 64'd0);
   endtask

   task automatic frame(input int idx, input logic [7:0] b, input string tag,
                        output int waited, output logic [63:0] got);
      logic [63:0] exp;
      int len;
      logic bok;
      model(idx, b, exp, len);
      wait_start(idx, waited);
      got = '0;
      bok = 1'b1;
      for (int k = 0; k < len; k++) begin
         got[k] = w_tx[idx];
         bok = bok & w_busy[idx];
         @(negedge clk);
      end
      check({tag, "_bits"}, got, exp);
      check({tag, "_busy"}, 64'(bok), 64'd1);
      check({tag, "_gap"}, 64'({w_tx[idx], w_busy[idx]}), 64'd2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n;
      logic [63:0] g;
      logic [7:0] b;
      logic low;
      for (int i = 0; i < 4; i++) begin
         val[i] = 1'b0;
         dat[i] = '0;
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_tx",   64'(w_tx),     64'hf);
      check("rst_busy", 64'(w_busy),   64'h0);
      check("rst_rdy",  64'(w_rdy),    64'hf);
      check("rst_cnt0", 64'(w_cnt[0]), 64'd0);
      check("rst_cnt3", 64'(w_cnt[3]), 64'd0);

      reset = 1'b1;
      push(0, 8'hA5);
      frame(0, 8'hA5, "a5", w, g);
      check("a5_lat", 64'(w), 64'd1);

      for (int r = 0; r < 3; r++) begin
         b = 8'($urandom);
         push(0, b);
         frame(0, b, "rnd0", w, g);
      end

      push(1, 8'h07);
      frame(1, 8'h07, "p_even", w, g);
      check("p_even_bit", 64'(g[36]), 64'd1);
      push(2, 8'h07);
      frame(2, 8'h07, "p_odd", w, g);
      check("p_odd_bit", 64'(g[36]), 64'd0);
      for (int i = 1; i < 4; i++) begin
         b = 8'($urandom);
         push(i, b);
         frame(i, b, "rndp", w, g);
      end

      fork
         begin
            for (int i = 0; i < 6; i++) begin
               val[0] = 1'b1;
               dat[0] = 8'(8'h11 + i);
               if (i == 5) begin
                  check("q_full_rdy", 64'(w_rdy[0]), 64'd0);
                  check("q_full_cnt", 64'(w_cnt[0]), 64'd4);
               end
               @(negedge clk);
            end
            val[0] = 1'b0;
         end
         begin
            int wq;
            logic [63:0] gq;
            for (int i = 0; i < 5; i++) begin
               frame(0, 8'(8'h11 + i), "q", wq, gq);
               if (i > 0) check("q_idle1", 64'(wq), 64'd1);
            end
         end
      join
      low = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (w_tx[0] !== 1'b1) low = 1'b1;
      end
      check("q_no6th", 64'(low), 64'd0);
      check("q_empty", 64'(w_cnt[0]), 64'd0);

      for (int i = 0; i < 5; i++) begin
         val[0] = 1'b1;
         dat[0] = 8'(8'h21 + i);
         @(negedge clk);
      end
      dat[0] = 8'h5A;
      check("f_full", 64'(w_cnt[0]), 64'd4);
      check("f_rdy0", 64'(w_rdy[0]), 64'd0);
      n = 0;
      while (w_cnt[0] === 3'd4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("f_pop_cnt", 64'(w_cnt[0]), 64'd3);
      check("f_pop_rdy", 64'(w_rdy[0]), 64'd1);
      @(negedge clk);
      val[0] = 1'b0;
      check("f_refill", 64'(w_cnt[0]), 64'd4);
      n = 0;
      while (!(w_cnt[0] === 3'd0 && w_busy[0] === 1'b0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("f_drain", 64'({w_cnt[0], w_busy[0]}), 64'd0);

      b = 8'h31;
      push(0, b);
      push(0, 8'h32);
      val[0] = 1'b1;
      dat[0] = 8'h33;
      @(negedge clk);
      val[0] = 1'b0;
      repeat (12) @(negedge clk);
      check("r_pre_bit", 64'(w_tx[0]), 64'(b[2]));
      check("r_pre_cnt", 64'(w_cnt[0]), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      check("r_tx_async", 64'(w_tx[0]), 64'd1);
      check("r_cnt",      64'(w_cnt[0]), 64'd0);
      check("r_busy",     64'(w_busy[0]), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      low = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) low = 1'b1;
      end
      check("r_quiet", 64'(low), 64'd0);
      b = 8'($urandom);
      push(0, b);
      frame(0, b, "r_after", w, g);

      push(3, 8'hFF);
      push(3, 8'h00);
      frame(3, 8'hFF, "s2_ff", w, g);
      frame(3, 8'h00, "s2_00", w, g);
      check("s2_idle1", 64'(w), 64'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Parameters
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, which inserts a parity bit when set to 1.
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, selecting even parity (0) or odd parity (1); it is ignored when PARITY_EN=0.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits (legal values 1 or 2).

Interface
REQ-005 clk  input  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 resets the block immediately, with synchronous release.
REQ-007 tx_data  input  8  byte offered for transmission.
REQ-008 tx_valid  input  1  tx_data is valid this cycle.
REQ-009 tx_ready  output  1  block can accept a byte; equal to (fifo_count != 4).
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  registered; high while the FSM is outside IDLE.
REQ-012 fifo_count  output  3  bytes held in the input FIFO (0..4).

Function
REQ-013 Handshake: a byte SHALL be written into a 4-entry FIFO on a rising edge where tx_valid=1 and tx_ready=1; with tx_valid=1 and tx_ready=0 the byte SHALL be ignored and not counted.
REQ-014 tx_ready SHALL depend only on the current fifo_count; a same-cycle pop SHALL NOT make a full FIFO writable in that cycle.
REQ-015 A push and a pop on the same edge SHALL leave fifo_count unchanged and preserve FIFO order; read and write pointers SHALL wrap modulo 4.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-017 IDLE: tx=1; if fifo_count>0, the next edge SHALL pop the head byte into the shift register, enter START, and set the baud counter to 0.
REQ-018 Each of START, DATA, PARITY and STOP-bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1.
REQ-019 START SHALL drive tx=0.
REQ-020 DATA SHALL send 8 bits LSB first using a bit index 0..7, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-021 PARITY SHALL drive (XOR of the 8 data bits) XOR PARITY_ODD.
REQ-022 STOP SHALL drive tx=1 for STOP_BITS x CLKS_PER_BIT cycles, then return to IDLE.
REQ-023 tx SHALL change only on baud-period boundaries, so each bit is a full CLKS_PER_BIT-cycle level with no glitches.
REQ-024 Back-to-back frames: IDLE SHALL last exactly 1 cycle (tx=1) between the end of a stop bit and the next start bit when the FIFO is non-empty.
REQ-025 Frame length SHALL be (1 + 8 + PARITY_EN + STOP_BITS) x CLKS_PER_BIT cycles from the first tx=0 cycle to the end of the last stop bit.
REQ-026 tx_data and tx_valid changes during a frame SHALL NOT affect the frame in progress, because the frame uses only the popped copy.
REQ-027 Writes while the FSM is busy SHALL be accepted up to FIFO capacity.

Reset
REQ-028 While reset=0: tx=1, tx_busy=0, fifo_count=0, tx_ready=1, FSM=IDLE, pointers, baud counter and bit index at 0, shift register at 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, force tx high asynchronously, and discard all FIFO contents.
REQ-030 A tx_valid applied in the first cycle after reset release SHALL be accepted normally.

Verification
REQ-031 CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total), with tx_busy high throughout.
REQ-032 PARITY_EN=1, PARITY_ODD=0, push 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame = 44 cycles at CLKS_PER_BIT=4.
REQ-033 Push 5 bytes 0x11..0x15 in consecutive cycles while idle -> first pops, next 4 fill the FIFO; the 6th push attempt with tx_ready=0 is dropped; serial output is 0x11..0x15 in order with a 1-cycle idle gap between frames.
REQ-034 FIFO full and frame ending: the pop cycle with tx_valid=1 -> write not accepted that cycle (tx_ready=0), accepted the next cycle, and fifo_count follows 4 -> 3 -> 4.
REQ-035 Assert reset at the 3rd data bit of a frame with 2 bytes queued -> tx=1 immediately, fifo_count=0; after release, no frame is sent until a new push.
REQ-036 STOP_BITS=2, push 0xFF, then 0x00 queued -> tx high for 8 stop cycles plus 1 idle cycle before the second start bit.
